// File: rtl/insn_prefetch_queue_pkg.sv
// Shared types for the instruction prefetch queue.
// Address/instruction widths and the ring entry layout.
package insn_prefetch_queue_pkg;

    localparam int INSN_ADDR_WIDTH = 10;
    localparam int INSN_WIDTH      = 32;

    typedef logic [INSN_ADDR_WIDTH-1:0] InsnAddrPath;
    typedef logic [INSN_WIDTH-1:0]      InsnPath;

    typedef struct packed {
        logic        filled;
        InsnAddrPath addr;
        InsnPath     insn;
    } PrefetchEntry;

endpackage

// File: rtl/insn_prefetch_queue_ring.sv
// In-order ring of prefetch slots: allocated at issue,
// filled at response, freed at retire, cleared by flush.
module prefetch_ring
    import insn_prefetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         alloc,
    input  logic [INSN_ADDR_WIDTH-1:0]   allocAddr,
    input  logic                         fill,
    input  logic [INSN_WIDTH-1:0]        fillInsn,
    input  logic                         retire,
    output logic                         headFilled,
    output logic [INSN_ADDR_WIDTH-1:0]   headAddr,
    output logic [INSN_WIDTH-1:0]        headInsn,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    PrefetchEntry   slots [DEPTH];
    logic [PW-1:0]  headPtr;
    logic [PW-1:0]  tailPtr;
    logic [PW-1:0]  fillPtr;

    // Alloc, fill and retire always address distinct slots, so
    // all three may update the array in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
            headPtr <= '0;
            tailPtr <= '0;
            fillPtr <= '0;
            count   <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i].filled <= 1'b0;
            end
            headPtr <= '0;
            tailPtr <= '0;
            fillPtr <= '0;
            count   <= '0;
        end else begin
            if (alloc) begin
                slots[tailPtr].addr   <= allocAddr;
                slots[tailPtr].filled <= 1'b0;
                tailPtr               <= tailPtr + PW'(1);
            end
            if (fill) begin
                slots[fillPtr].insn   <= fillInsn;
                slots[fillPtr].filled <= 1'b1;
                fillPtr               <= fillPtr + PW'(1);
            end
            if (retire) begin
                slots[headPtr].filled <= 1'b0;
                headPtr               <= headPtr + PW'(1);
            end
            count <= count + CW'(alloc) - CW'(retire);
        end
    end

    assign headFilled = slots[headPtr].filled;
    assign headAddr   = slots[headPtr].addr;
    assign headInsn   = slots[headPtr].insn;

endmodule

// File: rtl/insn_prefetch_queue.sv
// Prefetch stage ahead of IF/ID: sequential fetch, response
// buffering, redirect flush with in-flight response discard.
module insn_prefetch_queue
    import insn_prefetch_queue_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int MAX_OUTST = 2,
    parameter int ADDR_STEP = 1,
    parameter int RESET_PC  = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        redirect,
    input  logic [INSN_ADDR_WIDTH-1:0]  redirectAddr,
    output logic                        memReq,
    output logic [INSN_ADDR_WIDTH-1:0]  memAddr,
    input  logic                        memAck,
    input  logic                        memRspValid,
    input  logic [INSN_WIDTH-1:0]       memRspInsn,
    output logic                        deqValid,
    output logic [INSN_ADDR_WIDTH-1:0]  deqAddr,
    output logic [INSN_WIDTH-1:0]       deqInsn,
    input  logic                        deqReady
);

    localparam int AW = INSN_ADDR_WIDTH;
    localparam int OW = $clog2(MAX_OUTST+1);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0] fetchPC;
    logic [OW-1:0] outst;
    logic [OW-1:0] dropCnt;
    logic [CW-1:0] allocCnt;
    logic          headFilled;
    logic          issue;
    logic          rspSeen;
    logic          fill;
    logic          retire;

    assign rspSeen = memRspValid && (outst != '0);
    assign memReq  = rst && !redirect
                  && (allocCnt < CW'(DEPTH))
                  && (outst < OW'(MAX_OUTST));
    assign memAddr  = fetchPC;
    assign issue    = memReq && memAck;
    assign fill     = rspSeen && !redirect && (dropCnt == '0);
    assign deqValid = headFilled && !redirect;
    assign retire   = deqValid && deqReady;

    // outst already includes words queued for dropping, so on
    // redirect every request still in flight becomes a drop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetchPC <= AW'(RESET_PC);
            outst   <= '0;
            dropCnt <= '0;
        end else begin
            outst <= outst + OW'(issue) - OW'(rspSeen);
            if (redirect) begin
                fetchPC <= redirectAddr;
                dropCnt <= outst - OW'(rspSeen);
            end else begin
                if (issue) begin
                    fetchPC <= fetchPC + AW'(ADDR_STEP);
                end
                if (rspSeen && (dropCnt != '0)) begin
                    dropCnt <= dropCnt - OW'(1);
                end
            end
        end
    end

    prefetch_ring #(
        .DEPTH(DEPTH)
    ) uRing (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect),
        .alloc      (issue),
        .allocAddr  (fetchPC),
        .fill       (fill),
        .fillInsn   (memRspInsn),
        .retire     (retire),
        .headFilled (headFilled),
        .headAddr   (deqAddr),
        .headInsn   (deqInsn),
        .count      (allocCnt)
    );

endmodule
